// File: rtl/dff_q_checker_if.sv
// Signal bundle between a flop-under-test harness and the dff_q_checker monitor.
// START/STOP are single-cycle pulses sampled on CLK; there is no valid/ready pair.
interface dff_q_checker_if #(
  parameter int CNT_W = 16
);
  logic             START;
  logic             STOP;
  logic             D;
  logic             EN;
  logic             Q;
  logic             BUSY;
  logic             DONE;
  logic             ERR;
  logic [CNT_W-1:0] MISMATCH_CNT;
  logic [CNT_W-1:0] RISE_CNT;
  logic [CNT_W-1:0] FALL_CNT;
  logic [CNT_W-1:0] CYCLE_CNT;
  logic [CNT_W-1:0] FIRST_ERR_CYC;
  logic [1:0]       state_dbg;

  modport master (
    output START, STOP, D, EN, Q,
    input  BUSY, DONE, ERR, MISMATCH_CNT, RISE_CNT, FALL_CNT, CYCLE_CNT,
           FIRST_ERR_CYC, state_dbg
  );

  modport slave (
    input  START, STOP, D, EN, Q,
    output BUSY, DONE, ERR, MISMATCH_CNT, RISE_CNT, FALL_CNT, CYCLE_CNT,
           FIRST_ERR_CYC, state_dbg
  );
endinterface

// File: rtl/dff_q_checker.sv
// Golden-model monitor for a single-bit enabled D flop: compares Q with a registered
// prediction every cycle of a run, counts Q edges and records the first mismatch.
module dff_q_checker #(
  parameter int CNT_W   = 16,
  parameter int EN_POL  = 1,
  parameter int RUN_LEN = 0
) (
  input logic           CLK,
  input logic           RST,
  dff_q_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  localparam logic EN_LVL = (EN_POL != 0);

  state_t           state, state_nxt;
  logic             busy_r, done_r, err_r;
  logic             exp_r, q_prev;
  logic [CNT_W-1:0] mism_cnt, rise_cnt, fall_cnt, cyc_cnt, first_err;
  logic             en_act, mismatch, last_cmp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign en_act   = (bus.EN == EN_LVL);
  // Four-state compare so an X or Z on the observed Q is flagged.
  assign mismatch = (bus.Q !== exp_r);
  assign last_cmp = (RUN_LEN > 0) && ((32'(cyc_cnt) + 32'd1) == 32'(RUN_LEN));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.START) state_nxt = RUN;
      RUN:     if (bus.STOP || last_cmp) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_r <= (state_nxt == RUN);
      done_r <= (state_nxt == FIN);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_r     <= 1'b0;
      exp_r     <= 1'b0;
      q_prev    <= 1'b0;
      mism_cnt  <= '0;
      rise_cnt  <= '0;
      fall_cnt  <= '0;
      cyc_cnt   <= '0;
      first_err <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            err_r     <= 1'b0;
            mism_cnt  <= '0;
            rise_cnt  <= '0;
            fall_cnt  <= '0;
            cyc_cnt   <= '0;
            first_err <= '0;
            exp_r     <= en_act ? bus.D : bus.Q;
            q_prev    <= bus.Q;
          end
        end
        RUN: begin
          cyc_cnt <= sat_inc(cyc_cnt);
          if (mismatch) begin
            mism_cnt <= sat_inc(mism_cnt);
            if (!err_r) begin
              first_err <= cyc_cnt;
              err_r     <= 1'b1;
            end
          end
          if (!q_prev && bus.Q) rise_cnt <= sat_inc(rise_cnt);
          if (q_prev && !bus.Q) fall_cnt <= sat_inc(fall_cnt);
          q_prev <= bus.Q;
          if (en_act) exp_r <= bus.D;
        end
        default: ;
      endcase
    end
  end

  assign bus.BUSY          = busy_r;
  assign bus.DONE          = done_r;
  assign bus.ERR           = err_r;
  assign bus.MISMATCH_CNT  = mism_cnt;
  assign bus.RISE_CNT      = rise_cnt;
  assign bus.FALL_CNT      = fall_cnt;
  assign bus.CYCLE_CNT     = cyc_cnt;
  assign bus.FIRST_ERR_CYC = first_err;
  assign bus.state_dbg     = state;
endmodule

// File: tb/tb_dff_q_checker.sv
// Bench for dff_q_checker: four instances share one stimulus stream (unlimited run,
// auto-stop at 5, active-low enable, and a 3-bit counter copy for saturation).
module tb_dff_q_checker;
  localparam int W = 81;

  logic clk = 1'b0;
  logic rst_n;
  logic start, stop, d, en, q;
  logic golden;

  always #5 clk = ~clk;

  dff_q_checker_if #(.CNT_W(16)) a_if ();
  dff_q_checker_if #(.CNT_W(16)) b_if ();
  dff_q_checker_if #(.CNT_W(16)) c_if ();
  dff_q_checker_if #(.CNT_W(3))  d_if ();

  assign a_if.START = start; assign a_if.STOP = stop; assign a_if.D = d;
  assign a_if.EN = en;       assign a_if.Q = q;
  assign b_if.START = start; assign b_if.STOP = stop; assign b_if.D = d;
  assign b_if.EN = en;       assign b_if.Q = q;
  assign c_if.START = start; assign c_if.STOP = stop; assign c_if.D = d;
  assign c_if.EN = ~en;      assign c_if.Q = q;
  assign d_if.START = start; assign d_if.STOP = stop; assign d_if.D = d;
  assign d_if.EN = en;       assign d_if.Q = q;

  dff_q_checker #(.CNT_W(16), .EN_POL(1), .RUN_LEN(0)) dut_a (.CLK(clk), .RST(rst_n), .bus(a_if));
  dff_q_checker #(.CNT_W(16), .EN_POL(1), .RUN_LEN(5)) dut_b (.CLK(clk), .RST(rst_n), .bus(b_if));
  dff_q_checker #(.CNT_W(16), .EN_POL(0), .RUN_LEN(0)) dut_c (.CLK(clk), .RST(rst_n), .bus(c_if));
  dff_q_checker #(.CNT_W(3),  .EN_POL(1), .RUN_LEN(0)) dut_d (.CLK(clk), .RST(rst_n), .bus(d_if));

  // Scoreboard record: {err, first, cyc, mism, rise, fall}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rec;
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int b_done = 0;
  int b0;

  int   m_state, m_cyc, m_mm, m_rise, m_fall, m_first;
  logic m_err, m_exp, m_qp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] sat3(input logic [15:0] v);
    return (v > 16'd7) ? 32'd7 : 32'(v);
  endfunction

  task automatic model_reset();
    m_state = 0; m_cyc = 0; m_mm = 0; m_rise = 0; m_fall = 0; m_first = 0;
    m_err = 1'b0; m_exp = 1'b0; m_qp = 1'b0;
  endtask

  // Drive one cycle at the falling edge, advance the reference, then let the flop clock.
  task automatic step(input logic st, input logic sp, input logic dv, input logic ev, input int qmode);
    @(negedge clk);
    start = st; stop = sp; d = dv; en = ev;
    case (qmode)
      0:       q = golden;
      1:       q = ~golden;
      default: q = 1'bx;
    endcase
    case (m_state)
      0: if (start) begin
        m_state = 1; m_cyc = 0; m_mm = 0; m_rise = 0; m_fall = 0; m_first = 0;
        m_err = 1'b0; m_exp = en ? d : q; m_qp = q;
      end
      1: begin
        if (q !== m_exp) begin
          m_mm++;
          if (!m_err) begin m_first = m_cyc; m_err = 1'b1; end
        end
        if (m_qp === 1'b0 && q === 1'b1) m_rise++;
        if (m_qp === 1'b1 && q === 1'b0) m_fall++;
        m_qp = q;
        m_cyc++;
        if (en) m_exp = d;
        if (stop) begin
          m_state = 2;
          exp_q.push_back({m_err, 16'(m_first), 16'(m_cyc), 16'(m_mm), 16'(m_rise), 16'(m_fall)});
        end
      end
      default: m_state = 0;
    endcase
    @(posedge clk);
    if (ev) golden = dv;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1, 0);
  endtask

  always @(negedge clk) begin
    if (a_if.DONE) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        rec = exp_q.pop_front();
        check("a_err",   32'(a_if.ERR),           32'(rec[80]));
        check("a_first", 32'(a_if.FIRST_ERR_CYC), 32'(rec[79:64]));
        check("a_cyc",   32'(a_if.CYCLE_CNT),     32'(rec[63:48]));
        check("a_mism",  32'(a_if.MISMATCH_CNT),  32'(rec[47:32]));
        check("a_rise",  32'(a_if.RISE_CNT),      32'(rec[31:16]));
        check("a_fall",  32'(a_if.FALL_CNT),      32'(rec[15:0]));
        check("a_busy_at_done", 32'(a_if.BUSY), 32'd0);
        check("c_done",  32'(c_if.DONE),          32'd1);
        check("c_mism",  32'(c_if.MISMATCH_CNT),  32'(rec[47:32]));
        check("c_rise",  32'(c_if.RISE_CNT),      32'(rec[31:16]));
        check("d_cyc_sat",  32'(d_if.CYCLE_CNT),  sat3(rec[63:48]));
        check("d_mism_sat", 32'(d_if.MISMATCH_CNT), sat3(rec[47:32]));
      end
    end
    if (b_if.DONE) begin
      b_done++;
      check("b_cyc_at_done",  32'(b_if.CYCLE_CNT), 32'd5);
      check("b_busy_at_done", 32'(b_if.BUSY), 32'd0);
      check("b_before_stop",  32'(a_if.BUSY), 32'd1);
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; d = 1'b0; en = 1'b1; q = 1'b0;
    golden = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(a_if.BUSY), 32'd0);
    check("rst_done",  32'(a_if.DONE), 32'd0);
    check("rst_err",   32'(a_if.ERR), 32'd0);
    check("rst_cyc",   32'(a_if.CYCLE_CNT), 32'd0);
    check("rst_mism",  32'(a_if.MISMATCH_CNT), 32'd0);
    check("rst_first", 32'(a_if.FIRST_ERR_CYC), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Clean toggle run with a golden flop
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);
    for (int i = 1; i <= 10; i++) step(1'b0, 1'b0, 1'(i % 2), 1'b1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 0);
    idle(3);

    // Enable held off with D toggling, Q parked at 1
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 1'(i % 2), 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle(3);

    // Single inverted Q on the fourth compare
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b0, 1'(i % 2), 1'b1, (i == 4) ? 1 : 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 0);
    idle(4);
    #1;
    check("fault_err_sticky", 32'(a_if.ERR), 32'd1);
    check("fault_mism",       32'(a_if.MISMATCH_CNT), 32'd1);
    check("fault_first",      32'(a_if.FIRST_ERR_CYC), 32'd3);

    // Unknown Q for two compares while the prediction is 1
    step(1'b1, 1'b0, 1'b1, 1'b1, 0);
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b0, 1'b1, 1'b1, (i == 2 || i == 3) ? 2 : 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 0);
    idle(3);

    // START clears results; this run also exercises the auto-stop instance
    b0 = b_done;
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);
    #1;
    check("clr_err",   32'(a_if.ERR), 32'd0);
    check("clr_mism",  32'(a_if.MISMATCH_CNT), 32'd0);
    check("clr_cyc",   32'(a_if.CYCLE_CNT), 32'd0);
    check("clr_rise",  32'(a_if.RISE_CNT), 32'd0);
    check("clr_first", 32'(a_if.FIRST_ERR_CYC), 32'd0);
    check("run_busy",  32'(a_if.BUSY), 32'd1);
    for (int i = 1; i <= 7; i++) step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 0);
    idle(3);
    check("b_autostop_once", 32'(b_done - b0), 32'd1);

    // Asynchronous reset in the middle of a run with ERR already set
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(a_if.BUSY), 32'd0);
    check("arst_err",   32'(a_if.ERR), 32'd0);
    check("arst_cyc",   32'(a_if.CYCLE_CNT), 32'd0);
    check("arst_mism",  32'(a_if.MISMATCH_CNT), 32'd0);
    check("arst_rise",  32'(a_if.RISE_CNT), 32'd0);
    check("arst_fall",  32'(a_if.FALL_CNT), 32'd0);
    check("arst_first", 32'(a_if.FIRST_ERR_CYC), 32'd0);
    check("arst_b_busy", 32'(b_if.BUSY), 32'd0);
    model_reset();
    @(posedge clk);
    #1 check("arst_no_done", 32'(a_if.DONE), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // START and STOP together in IDLE, random D/EN; active-low copy sees inverted EN
    step(1'b1, 1'b1, 1'b0, 1'b1, 0);
    #1 check("start_wins", 32'(a_if.BUSY), 32'd1);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 0);
    idle(4);

    check("queue_empty",  32'(exp_q.size()), 32'd0);
    check("done_count",   32'(done_cnt), 32'd6);
    check("b_done_count", 32'(b_done), 32'd6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
